// File: rtl/traffic_light_ctrl_n.sv
// N-direction traffic light FSM: tick-timed GREEN/YELLOW/ALLRED(/WALK) phases, round-robin
// direction rotation with sensor skip. Optional pedestrian WALK phase via TLC_PED_WALK_EN.
module traffic_light_ctrl_n #(
  parameter int NUM_DIR    = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 5,
  localparam int DIR_W     = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               ped_req,
  input  logic [NUM_DIR-1:0] sensor,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic               walk,
  output logic [1:0]         phase,
  output logic [DIR_W-1:0]   active_dir
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);

  state_t           state_q, state_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [DIR_W-1:0] nxt_dir, cand;
  logic             found;
  logic             ped_pend_q;

  // Search from dir+1 so the current owner is only re-granted when nobody else is waiting.
  always_comb begin
    nxt_dir = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      cand = DIR_W'((int'(dir_q) + k) % NUM_DIR);
      if (!found && sensor[cand]) begin
        found   = 1'b1;
        nxt_dir = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    if (tick) begin
      if (timer_q == '0) begin
        unique case (state_q)
          ST_GREEN: begin
            state_d = ST_YELLOW;
            timer_d = YELLOW_LD;
          end
          ST_YELLOW: begin
            state_d = ST_ALLRED;
            timer_d = ALLRED_LD;
          end
          ST_ALLRED: begin
            if (ped_pend_q) begin
              state_d = ST_WALK;
              timer_d = CNT_W'(WALK_CYC - 1);
            end else begin
              state_d = ST_GREEN;
              dir_d   = nxt_dir;
              timer_d = GREEN_LD;
            end
          end
          default: begin
            state_d = ST_GREEN;
            dir_d   = nxt_dir;
            timer_d = GREEN_LD;
          end
        endcase
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALLRED;
      dir_q   <= LAST_DIR;
      timer_q <= ALLRED_LD;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

`ifdef TLC_PED_WALK_EN
  logic ped_pend_d;

  // Clearing on WALK entry wins, so a press on the entry cycle is absorbed.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (ped_req && (state_q != ST_WALK)) ped_pend_d = 1'b1;
    if ((state_d == ST_WALK) && (state_q != ST_WALK)) ped_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ped_pend_q <= 1'b0;
    else        ped_pend_q <= ped_pend_d;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend_q     = 1'b0;
`endif

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '1;
    unique case (state_q)
      ST_GREEN: begin
        green[dir_q] = 1'b1;
        red[dir_q]   = 1'b0;
      end
      ST_YELLOW: begin
        yellow[dir_q] = 1'b1;
        red[dir_q]    = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef TLC_PED_WALK_EN
  assign walk = (state_q == ST_WALK);
`else
  assign walk = 1'b0;
`endif

  assign phase      = state_q;
  assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Scoreboard bench for traffic_light_ctrl_n (default parameters): a phase/elapsed-tick reference
// model queues the expected lamps per clock; a monitor compares them against the DUT.
module tb_traffic_light_ctrl_n;
  localparam int N = 4;
`ifdef TLC_PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic       w;
    logic [1:0] ph;
    logic [1:0] ad;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       ped_req;
  logic [3:0] sensor;
  logic [3:0] green, yellow, red;
  logic       walk;
  logic [1:0] phase;
  logic [1:0] active_dir;

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  // Reference model: phase (0 ALLRED,1 GREEN,2 YELLOW,3 WALK), owner, ticks spent in phase.
  int m_phase, m_dir, m_elapsed;
  bit m_pend;

  traffic_light_ctrl_n dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req), .sensor(sensor),
    .green(green), .yellow(yellow), .red(red), .walk(walk),
    .phase(phase), .active_dir(active_dir)
  );

  always #5 clk = ~clk;

  function automatic int plen(input int ph);
    case (ph)
      0: return 2;
      1: return 8;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int next_dir(input int d, input logic [3:0] sn);
    for (int k = 1; k <= N; k++) begin
      if (sn[2'((d + k) % N)]) return (d + k) % N;
    end
    return (d + 1) % N;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.g  = (m_phase == 1) ? 4'(1 << m_dir) : 4'b0;
    o.y  = (m_phase == 2) ? 4'(1 << m_dir) : 4'b0;
    o.r  = ~(o.g | o.y);
    o.w  = (m_phase == 3);
    o.ph = 2'(m_phase);
    o.ad = 2'(m_dir);
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_dir = N - 1; m_elapsed = 0; m_pend = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit pr, input logic [3:0] sn);
    int  old_ph;
    bit  set_req;
    old_ph  = m_phase;
    set_req = PED && pr && (m_phase != 3);
    if (tk) begin
      if (m_elapsed + 1 >= plen(m_phase)) begin
        m_elapsed = 0;
        case (m_phase)
          1: m_phase = 2;
          2: m_phase = 0;
          0: if (PED && m_pend) m_phase = 3;
             else begin m_phase = 1; m_dir = next_dir(m_dir, sn); end
          default: begin m_phase = 1; m_dir = next_dir(m_dir, sn); end
        endcase
      end else begin
        m_elapsed++;
      end
    end
    if (m_phase == 3 && old_ph != 3) m_pend = 1'b0;
    else                             m_pend = m_pend | set_req;
  endtask

  task automatic cycle(input bit rst, input bit tk, input bit pr, input logic [3:0] sn);
    @(negedge clk);
    rst_n = rst; tick = tk; ped_req = pr; sensor = sn;
    if (!rst) model_reset();
    else      model_step(tk, pr, sn);
    exp_q.push_back(model_obs());
  endtask

  task automatic run_until(input int ph, input int dr, input int budget, input string name);
    int n;
    n = 0;
    while (!(m_phase == ph && (dr < 0 || m_dir == dr)) && n < budget) begin
      cycle(1'b1, 1'b1, 1'b0, 4'b0);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s: model phase %0d dir %0d not reached, budget %0d expired", name, ph, dr, budget);
    end
  endtask

  // Monitor: every clock the DUT presents a lamp vector; compare against the queued expectation.
  initial begin
    obs_t act, expv;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act  = {green, yellow, red, walk, phase, active_dir};
        vectors++;
        if (act !== expv) begin
          miscompares++;
          $display("FAIL lamps @%0t: got g=%b y=%b r=%b w=%b ph=%0d dir=%0d, want g=%b y=%b r=%b w=%b ph=%0d dir=%0d",
                   $time, act.g, act.y, act.r, act.w, act.ph, act.ad,
                   expv.g, expv.y, expv.r, expv.w, expv.ph, expv.ad);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; tick = 1'b1; ped_req = 1'b0; sensor = 4'b0;
    model_reset();

    // Reset state and first green after release
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'($urandom % 2), 4'($urandom));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0);

    // Plain rotation with wrap 3 -> 0
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0);

    // Sensor skip
    run_until(1, 0, 80, "reach_green0");
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 4'b1000);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0001);

    // Pedestrian request during green[1], then hold ped_req through any WALK
    run_until(1, 1, 80, "reach_green1");
    cycle(1'b1, 1'b1, 1'b1, 4'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, (m_phase == 3), 4'b0);

    // Tick gating: every 4th clk, then frozen
    for (int i = 0; i < 120; i++) cycle(1'b1, (i % 4 == 3), 1'b0, 4'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'($urandom % 2), 4'($urandom));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0);

    // Async reset mid-yellow with a pending request
    run_until(1, -1, 80, "reach_green");
    cycle(1'b1, 1'b1, 1'b1, 4'b0);
    run_until(2, -1, 40, "reach_yellow");
    cycle(1'b1, 1'b1, 1'b0, 4'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (red !== 4'b1111 || green !== 4'b0 || yellow !== 4'b0 || phase !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: got r=%b g=%b y=%b ph=%0d, want r=1111 g=0000 y=0000 ph=0",
               red, green, yellow, phase);
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 300) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
            (($urandom % 3) == 0) ? 4'b0 : 4'($urandom));

    cycle(1'b1, 1'b1, 1'b0, 4'b0);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
